nrzi_frame_decoder: RTL

Receive-side counterpart of the team's 2-bit toggle encoder. That encoder advances its state on every `1` input bit and emits the state LSB, so its line output toggles once per `1` (NRZI-style). This block samples that line, recovers the original bit stream (bit = line XOR previous line) and mirrors the encoder's 2-bit state counter. It then hunts for a sync word and deserializes a fixed-length frame of words into a valid/ready output port with overflow reporting.

---
 rtl/nrzi_pkg.sv | 16 +
 rtl/nrzi_frame_decoder_bit_decoder.sv | 33 +++
 rtl/nrzi_frame_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/nrzi_pkg.sv
// Shared definitions for the NRZI toggle encoder/decoder pair: FSM state,
// default frame geometry and the 2-bit phase type mirrored from the encoder.
package nrzi_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } nrzi_state_t;

    typedef logic [1:0] phase_t;

    localparam int         DEF_DATA_W      = 8;
    localparam logic [7:0] DEF_SYNC_WORD   = 8'hD5;
    localparam int         DEF_FRAME_WORDS = 4;

endpackage

// File: rtl/nrzi_frame_decoder_bit_decoder.sv
// NRZI line decoder: recovers bit = line XOR previous line and tracks the
// encoder's 2-bit state, which advances once per decoded '1'.
module nrzi_bit_decoder
    import nrzi_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   line_in,
    output logic   d,
    output logic   dec_bit,
    output phase_t phase
);

    logic line_q;

    // Combinational decode feeds the framer on the same edge it is registered here.
    assign d = line_in ^ line_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= 1'b0;
            dec_bit <= 1'b0;
            phase   <= '0;
        end else begin
            line_q  <= line_in;
            dec_bit <= d;
            if (d) begin
                phase <= phase + 2'd1;
            end
        end
    end

endmodule

// File: rtl/nrzi_frame_decoder.sv
// NRZI receive framer: decodes the line, hunts for SYNC_WORD, then deserializes
// FRAME_WORDS words MSB first into a valid/ready register with overflow pulses.
module nrzi_frame_decoder
    import nrzi_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(DEF_SYNC_WORD),
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_in,
    output logic              dec_bit,
    output phase_t            phase,
    output logic              frame_active,
    output logic              sync_found,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overflow
);

    localparam int BC_W = $clog2(DATA_W);
    localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(FRAME_WORDS - 1);

    logic              d;
    nrzi_state_t       state;
    logic [DATA_W-2:0] sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [DATA_W-1:0] word_in;

    nrzi_bit_decoder u_bit_decoder (
        .clk     (clk),
        .reset   (reset),
        .line_in (line_in),
        .d       (d),
        .dec_bit (dec_bit),
        .phase   (phase)
    );

    // The oldest shifted bit is never compared; the word in flight is {sr, d}.
    assign word_in = {sr, d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HUNT;
            frame_active <= 1'b0;
            sr           <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            sync_found   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            sr         <= word_in[DATA_W-2:0];
            sync_found <= 1'b0;
            overflow   <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            case (state)
                HUNT: begin
                    if (word_in == SYNC_WORD) begin
                        state        <= DATA;
                        frame_active <= 1'b1;
                        sync_found   <= 1'b1;
                        bit_cnt      <= '0;
                        word_cnt     <= '0;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        // A held word blocks the new one unless it is consumed this edge.
                        if (!data_valid || data_ready) begin
                            data_out   <= word_in;
                            data_valid <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (word_cnt == WORD_LAST) begin
                            state        <= HUNT;
                            frame_active <= 1'b0;
                            sr           <= '0;
                            word_cnt     <= '0;
                        end else begin
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
